// File: rtl/mmu_pkg.sv
// Shared definitions for the MMU/TLB front end: address split, PTE bit
// positions, FSM state encoding and the TLB entry payload.
package mmu_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned PAGE_BITS = 12;
    localparam int unsigned VPN_BITS  = ADDR_W - PAGE_BITS;

    // PTE layout: [31:PAGE_BITS] PPN, [PTE_W] writable, [PTE_V] valid
    localparam int unsigned PTE_V = 0;
    localparam int unsigned PTE_W = 1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOOKUP     = 3'd1,
        ST_WALK_REQ   = 3'd2,
        ST_WALK_WAIT  = 3'd3,
        ST_ISSUE      = 3'd4,
        ST_WAIT_CACHE = 3'd5,
        ST_DONE       = 3'd6,
        ST_FAULT      = 3'd7
    } mmu_state_e;

    typedef struct packed {
        logic                valid;
        logic                writable;
        logic [VPN_BITS-1:0] vpn;
        logic [VPN_BITS-1:0] ppn;
    } tlb_entry_t;

endpackage

// File: rtl/mmu_tlb_array.sv
// Fully-associative TLB storage.
// Ports: lookup_vpn_i -> hit_c_o/hit_ppn_c_o/hit_w_c_o (combinational compare,
// lowest index wins); fill_i writes the victim entry; flush_i clears all valid
// bits and the round-robin pointer (flush has priority over fill).
module tlb_array
    import mmu_pkg::*;
#(
    parameter int unsigned ENTRIES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [VPN_BITS-1:0] lookup_vpn_i,
    output logic                hit_c_o,
    output logic [VPN_BITS-1:0] hit_ppn_c_o,
    output logic                hit_w_c_o,
    input  logic                fill_i,
    input  logic [VPN_BITS-1:0] fill_vpn_i,
    input  logic [VPN_BITS-1:0] fill_ppn_i,
    input  logic                fill_w_i,
    input  logic                flush_i
);

    localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    tlb_entry_t       entry_q [ENTRIES];
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] victim_idx;
    logic             have_free;

    // Parallel compare; scanning downward lets the lowest matching index win.
    always_comb begin
        hit_c_o     = 1'b0;
        hit_ppn_c_o = '0;
        hit_w_c_o   = 1'b0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (entry_q[i].valid && (entry_q[i].vpn == lookup_vpn_i)) begin
                hit_c_o     = 1'b1;
                hit_ppn_c_o = entry_q[i].ppn;
                hit_w_c_o   = entry_q[i].writable;
            end
        end
    end

    // Victim: lowest invalid entry, else the round-robin slot.
    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!entry_q[i].valid) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
        victim_idx = have_free ? free_idx : rr_q;
    end

    // Entry storage and rr pointer; rr only advances when an entry is evicted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                entry_q[i] <= '0;
            end
        end else if (flush_i) begin
            rr_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                entry_q[i].valid <= 1'b0;
            end
        end else if (fill_i) begin
            entry_q[victim_idx] <= '{valid: 1'b1, writable: fill_w_i,
                                     vpn: fill_vpn_i, ppn: fill_ppn_i};
            if (!have_free) begin
                rr_q <= rr_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/mmu_tlb.sv
// Virtual-to-physical translation stage in front of cache_controller.
// CPU side: cpu_req/cpu_we/cpu_vaddr/cpu_wdata in, cpu_busy/cpu_done/cpu_fault
// and pass-through cpu_rdata out. Walker side: ptbr, tlb_flush, pte_addr,
// pte_read_req, pte_data_in, pte_ready. Cache side: phy_addr, data_from_cpu,
// read_mem/write_mem pulses, cache_ready_stall, cache_data_to_cpu.
module mmu_tlb
    import mmu_pkg::*;
#(
    parameter int unsigned TLB_ENTRIES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_vaddr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_fault,
    output logic [31:0]       cpu_rdata,
    input  logic [ADDR_W-1:0] ptbr,
    input  logic              tlb_flush,
    output logic [ADDR_W-1:0] pte_addr,
    output logic              pte_read_req,
    input  logic [31:0]       pte_data_in,
    input  logic              pte_ready,
    output logic [ADDR_W-1:0] phy_addr,
    output logic [31:0]       data_from_cpu,
    output logic              read_mem,
    output logic              write_mem,
    input  logic              cache_ready_stall,
    input  logic [31:0]       cache_data_to_cpu
);

    mmu_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   vaddr_q;
    logic [31:0]         wdata_q;
    logic                we_q;
    logic [ADDR_W-1:0]   phy_addr_q;
    logic [ADDR_W-1:0]   pte_addr_q;
    logic                busy_q, done_q, fault_q, pte_req_q, rd_q, wr_q;
    logic                fill_c;
    logic [VPN_BITS-1:0] vpn;
    logic                hit_c;
    logic [VPN_BITS-1:0] hit_ppn_c;
    logic                hit_w_c;
    logic                unused_pte_bits;

    assign vpn             = vaddr_q[ADDR_W-1:PAGE_BITS];
    assign unused_pte_bits = ^pte_data_in[PAGE_BITS-1:PTE_W+1];

    tlb_array #(
        .ENTRIES (TLB_ENTRIES)
    ) u_tlb (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_vpn_i (vpn),
        .hit_c_o      (hit_c),
        .hit_ppn_c_o  (hit_ppn_c),
        .hit_w_c_o    (hit_w_c),
        .fill_i       (fill_c),
        .fill_vpn_i   (vpn),
        .fill_ppn_i   (pte_data_in[ADDR_W-1:PAGE_BITS]),
        .fill_w_i     (pte_data_in[PTE_W]),
        .flush_i      (tlb_flush)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and TLB fill strobe
    always_comb begin
        state_d = state_q;
        fill_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (!hit_c)                 state_d = ST_WALK_REQ;
                else if (we_q && !hit_w_c)  state_d = ST_FAULT;
                else                        state_d = ST_ISSUE;
            end
            ST_WALK_REQ: state_d = ST_WALK_WAIT;
            ST_WALK_WAIT: begin
                if (pte_ready) begin
                    if (!pte_data_in[PTE_V]) begin
                        state_d = ST_FAULT;
                    end else begin
                        // A coincident flush drops the fill; the retry misses and re-walks.
                        state_d = ST_LOOKUP;
                        fill_c  = !tlb_flush;
                    end
                end
            end
            ST_ISSUE: begin
                if (!cache_ready_stall) state_d = ST_WAIT_CACHE;
            end
            ST_WAIT_CACHE: begin
                // Skip the cycle carrying the request pulse so the cache can raise stall.
                if (!(rd_q || wr_q) && !cache_ready_stall) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request latches, translated/PTE addresses and registered output strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vaddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            phy_addr_q <= '0;
            pte_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            pte_req_q  <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && cpu_req) begin
                vaddr_q <= cpu_vaddr;
                wdata_q <= cpu_wdata;
                we_q    <= cpu_we;
            end
            if (state_q == ST_LOOKUP) begin
                if (hit_c) phy_addr_q <= {hit_ppn_c, vaddr_q[PAGE_BITS-1:0]};
                else       pte_addr_q <= ptbr + ADDR_W'({vpn, 2'b00});
            end
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
            fault_q   <= (state_d == ST_FAULT);
            pte_req_q <= (state_d == ST_WALK_REQ);
            rd_q      <= (state_q == ST_ISSUE) && !cache_ready_stall && !we_q;
            wr_q      <= (state_q == ST_ISSUE) && !cache_ready_stall &&  we_q;
        end
    end

    assign cpu_busy      = busy_q;
    assign cpu_done      = done_q;
    assign cpu_fault     = fault_q;
    assign cpu_rdata     = cache_data_to_cpu;
    assign pte_addr      = pte_addr_q;
    assign pte_read_req  = pte_req_q;
    assign phy_addr      = phy_addr_q;
    assign data_from_cpu = wdata_q;
    assign read_mem      = rd_q;
    assign write_mem     = wr_q;

endmodule
